// File: rtl/data_bus_transmit.sv
// Lane transmit path: emits SLOS, Gen3/Gen4 ordered sets or transport data on two byte lanes.
// Outputs describe the byte currently on the lanes; the next byte is computed from the next state/count.
module data_bus_transmit #(
  parameter int          SLOS_BYTES = 256,
  parameter int          PRBS_BYTES = 32,
  parameter logic [10:0] G4_SEED_L0 = 11'h7FF,
  parameter logic [10:0] G4_SEED_L1 = 11'h0FF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lane_tx_on,
  input  logic [3:0] d_sel,
  input  logic [7:0] transport_layer_data_in,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] lane_0_tx,
  output logic [7:0] lane_1_tx,
  output logic       data_os,
  output logic       os_sent
);

  typedef enum logic [2:0] {IDLE, SLOS, G3TS, G4HDR, G4PRBS, G4TS, DATA} state_t;

  state_t      state, state_n;
  logic [1:0]  kind, kind_n;
  logic [8:0]  cnt, cnt_n;
  logic [10:0] lfsr0, lfsr0_n, lfsr1, lfsr1_n;
  logic [7:0]  lane0_n, lane1_n;
  logic        data_os_n, os_sent_n, tx_ready_n, start;
  logic [63:0] g3_l0, g3_l1;
  logic [31:0] g4_w;

  function automatic logic [7:0] prbs_byte(input logic [10:0] s);
    logic [10:0] t;
    logic [7:0]  b;
    t = s;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[7-i] = t[10];
      t = {t[9:0], t[10] ^ t[8]};
    end
    return b;
  endfunction

  function automatic logic [10:0] prbs_adv(input logic [10:0] s);
    logic [10:0] t;
    t = s;
    for (int i = 0; i < 8; i++) t = {t[9:0], t[10] ^ t[8]};
    return t;
  endfunction

  // Index of the final byte of a frame; G4HDR is the head of the TS1 frame
  function automatic logic [8:0] last_idx(input state_t s);
    case (s)
      SLOS:          last_idx = 9'(SLOS_BYTES);
      G3TS:          last_idx = 9'd7;
      G4HDR, G4PRBS: last_idx = 9'(PRBS_BYTES + 3);
      G4TS:          last_idx = 9'd3;
      default:       last_idx = 9'd0;
    endcase
  endfunction

  always_comb begin
    state_n    = state;
    kind_n     = kind;
    cnt_n      = (cnt >= last_idx(state)) ? cnt : cnt + 9'd1;
    lfsr0_n    = lfsr0;
    lfsr1_n    = lfsr1;
    lane0_n    = 8'h00;
    lane1_n    = 8'h00;
    data_os_n  = 1'b0;
    start      = 1'b0;
    g3_l0      = '0;
    g3_l1      = '0;
    g4_w       = '0;
    if (state == G4HDR && cnt == 9'd3) state_n = G4PRBS;
    case (state)
      IDLE:    start = 1'b1;
      DATA:    if (d_sel != 4'd8) state_n = IDLE;
      default: start = os_sent;
    endcase
    if (start) begin
      cnt_n  = '0;
      kind_n = d_sel[1:0];
      case (d_sel)
        4'd0, 4'd1:       begin state_n = SLOS; lfsr0_n = 11'h400; end
        4'd2, 4'd3:       state_n = G3TS;
        4'd4:             begin state_n = G4HDR; lfsr0_n = G4_SEED_L0; lfsr1_n = G4_SEED_L1; end
        4'd5, 4'd6, 4'd7: state_n = G4TS;
        4'd8:             state_n = DATA;
        default:          state_n = IDLE;
      endcase
    end
    case (state_n)
      SLOS: begin
        if (cnt_n == 9'd0) lane0_n = 8'h40;
        else begin
          lane0_n = prbs_byte(lfsr0);
          lfsr0_n = prbs_adv(lfsr0);
        end
        if (kind_n[0]) lane0_n = ~lane0_n;
        lane1_n = lane0_n;
      end
      G3TS: begin
        g3_l0   = {48'h0100_0000_0400, kind_n[0] ? 8'h64 : 8'h98, 8'hF2};
        g3_l1   = g3_l0 | 64'h0001_0000_0000_0000;
        lane0_n = g3_l0[{3'd7 - cnt_n[2:0], 3'b000} +: 8];
        lane1_n = g3_l1[{3'd7 - cnt_n[2:0], 3'b000} +: 8];
      end
      G4HDR, G4TS: begin
        if (state_n == G4HDR)   g4_w = 32'h7E02_D0F0;
        else if (kind_n == 2'd1) g4_w = 32'h7E04_B0F0;
        else if (kind_n == 2'd2) g4_w = 32'h7E06_90F0;
        else                     g4_w = 32'h7E0F_0F00;
        lane0_n = g4_w[{2'd3 - cnt_n[1:0], 3'b000} +: 8];
        lane1_n = lane0_n;
      end
      G4PRBS: begin
        lane0_n = prbs_byte(lfsr0);
        lane1_n = prbs_byte(lfsr1);
        lfsr0_n = prbs_adv(lfsr0);
        lfsr1_n = prbs_adv(lfsr1);
      end
      default: ;
    endcase
    // A byte accepted on the last DATA cycle still drains even when leaving DATA
    if (state == DATA && tx_valid && tx_ready) begin
      lane0_n   = transport_layer_data_in;
      data_os_n = 1'b1;
    end
    os_sent_n  = (state_n inside {SLOS, G3TS, G4PRBS, G4TS}) && (cnt_n == last_idx(state_n));
    tx_ready_n = (state_n == DATA);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE; kind <= '0; cnt <= '0;
      lfsr0 <= 11'h400; lfsr1 <= G4_SEED_L1;
      lane_0_tx <= '0; lane_1_tx <= '0; data_os <= 1'b0; os_sent <= 1'b0; tx_ready <= 1'b0;
    end else if (!lane_tx_on) begin
      state <= IDLE; kind <= '0; cnt <= '0;
      lfsr0 <= 11'h400; lfsr1 <= G4_SEED_L1;
      lane_0_tx <= '0; lane_1_tx <= '0; data_os <= 1'b0; os_sent <= 1'b0; tx_ready <= 1'b0;
    end else begin
      state <= state_n; kind <= kind_n; cnt <= cnt_n;
      lfsr0 <= lfsr0_n; lfsr1 <= lfsr1_n;
      lane_0_tx <= lane0_n; lane_1_tx <= lane1_n;
      data_os <= data_os_n; os_sent <= os_sent_n; tx_ready <= tx_ready_n;
    end
  end

endmodule

// File: tb/tb_data_bus_transmit.sv
// Randomized self-checking bench for data_bus_transmit; expected frames come from a
// bit-sequence PRBS model and the literal ordered-set tables.
module tb_data_bus_transmit;
  localparam int SB = 256;
  localparam int PB = 32;

  logic       clk = 1'b0;
  logic       rst, lane_tx_on, tx_valid, tx_ready, data_os, os_sent;
  logic [3:0] d_sel;
  logic [7:0] din, l0, l1;

  int total = 0;
  int bad   = 0;

  logic [7:0] e0 [0:299];
  logic [7:0] e1 [0:299];
  int         elen;
  bit         pb [0:2200];

  data_bus_transmit #(.SLOS_BYTES(SB), .PRBS_BYTES(PB)) dut (
    .clk(clk), .rst(rst), .lane_tx_on(lane_tx_on), .d_sel(d_sel),
    .transport_layer_data_in(din), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .lane_0_tx(l0), .lane_1_tx(l1), .data_os(data_os), .os_sent(os_sent)
  );

  always #5 clk = ~clk;

  // PRBS11 output bits obey out[n+11] = out[n] ^ out[n+2]; first 11 bits are the seed, MSB first
  task automatic prbs_fill(input logic [10:0] seed, input int n, input int lane, input int off);
    logic [7:0] b;
    for (int i = 0; i < 11; i++) pb[i] = seed[10-i];
    for (int i = 11; i < 8*n; i++) pb[i] = pb[i-11] ^ pb[i-9];
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 8; j++) b[7-j] = pb[8*k+j];
      if (lane == 0) e0[off+k] = b; else e1[off+k] = b;
    end
  endtask

  task automatic build_frame(input int code);
    logic [63:0] w0, w1;
    logic [31:0] h;
    case (code)
      0, 1: begin
        elen = 1 + SB;
        e0[0] = 8'h40;
        prbs_fill(11'h400, SB, 0, 1);
        for (int k = 0; k < elen; k++) begin
          if (code == 1) e0[k] = ~e0[k];
          e1[k] = e0[k];
        end
      end
      2, 3: begin
        elen = 8;
        w0 = (code == 2) ? 64'h0100_0000_0400_98F2 : 64'h0100_0000_0400_64F2;
        w1 = (code == 2) ? 64'h0101_0000_0400_98F2 : 64'h0101_0000_0400_64F2;
        for (int k = 0; k < 8; k++) begin
          e0[k] = w0[63-8*k -: 8];
          e1[k] = w1[63-8*k -: 8];
        end
      end
      4: begin
        elen = 4 + PB;
        h = 32'h7E02_D0F0;
        for (int k = 0; k < 4; k++) begin e0[k] = h[31-8*k -: 8]; e1[k] = e0[k]; end
        prbs_fill(11'h7FF, PB, 0, 4);
        prbs_fill(11'h0FF, PB, 1, 4);
      end
      default: begin
        elen = 4;
        h = (code == 5) ? 32'h7E04_B0F0 : (code == 6) ? 32'h7E06_90F0 : 32'h7E0F_0F00;
        for (int k = 0; k < 4; k++) begin e0[k] = h[31-8*k -: 8]; e1[k] = e0[k]; end
      end
    endcase
  endtask

  function automatic logic [3:0] idle_code();
    return 4'($urandom_range(9, 15));
  endfunction

  task automatic test_reset();
    rst = 1'b0; lane_tx_on = 1'b0; d_sel = 4'd0; tx_valid = 1'b0; din = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({l0, l1, os_sent, data_os, tx_ready} !== 19'h0) begin
      bad++; $display("FAIL reset_state got=%h exp=0", {l0, l1, os_sent, data_os, tx_ready});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({l0, l1, os_sent, data_os, tx_ready} !== 19'h0) begin
      bad++; $display("FAIL tx_off_idle got=%h exp=0", {l0, l1, os_sent, data_os, tx_ready});
    end
    lane_tx_on = 1'b1; d_sel = idle_code();
    @(posedge clk); @(negedge clk);
    total++;
    if ({l0, l1, os_sent, data_os, tx_ready} !== 19'h0) begin
      bad++; $display("FAIL idle_code_zero got=%h exp=0", {l0, l1, os_sent, data_os, tx_ready});
    end
  endtask

  // Every ordered-set code in random order: two repeated frames, then idle
  task automatic test_os_frames();
    int codes [8];
    int j, t;
    for (int i = 0; i < 8; i++) codes[i] = i;
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(0, i); t = codes[i]; codes[i] = codes[j]; codes[j] = t;
    end
    for (int c = 0; c < 8; c++) begin
      build_frame(codes[c]);
      d_sel = 4'(codes[c]);
      for (int f = 0; f < 2; f++) begin
        for (int k = 0; k < elen; k++) begin
          @(posedge clk); @(negedge clk);
          total++;
          if ({l0, l1, os_sent, data_os} !== {e0[k], e1[k], k == elen - 1, 1'b0}) begin
            bad++;
            $display("FAIL os_code%0d_f%0d_b%0d got=%h exp=%h", codes[c], f, k,
                     {l0, l1, os_sent, data_os}, {e0[k], e1[k], k == elen - 1, 1'b0});
          end
        end
      end
      d_sel = idle_code();
      @(posedge clk); @(negedge clk);
      total++;
      if ({l0, l1, os_sent, data_os, tx_ready} !== 19'h0) begin
        bad++; $display("FAIL os_code%0d_to_idle got=%h exp=0", codes[c], {l0, l1, os_sent, data_os, tx_ready});
      end
    end
  endtask

  // TS1 -> TS2 request mid-frame takes effect only after os_sent
  task automatic test_midframe_switch();
    int sw;
    sw = $urandom_range(1, 30);
    build_frame(4);
    d_sel = 4'd4;
    for (int k = 0; k < elen; k++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ({l0, l1, os_sent} !== {e0[k], e1[k], k == elen - 1}) begin
        bad++; $display("FAIL switch_ts1_b%0d got=%h exp=%h", k, {l0, l1, os_sent}, {e0[k], e1[k], k == elen - 1});
      end
      if (k == sw) d_sel = 4'd5;
    end
    build_frame(5);
    for (int k = 0; k < elen; k++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ({l0, l1, os_sent} !== {e0[k], e1[k], k == elen - 1}) begin
        bad++; $display("FAIL switch_ts2_b%0d got=%h exp=%h", k, {l0, l1, os_sent}, {e0[k], e1[k], k == elen - 1});
      end
    end
    d_sel = idle_code();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_data();
    logic       v;
    logic [7:0] d;
    d_sel = 4'd8; tx_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if ({l0, l1, os_sent, data_os, tx_ready} !== 19'h1) begin
      bad++; $display("FAIL data_entry got=%h exp=00001", {l0, l1, os_sent, data_os, tx_ready});
    end
    for (int n = 0; n < 24; n++) begin
      if (n == 0)      begin v = 1'b1; d = 8'hA5; end
      else if (n == 1) begin v = 1'b1; d = 8'h3C; end
      else if (n == 2) begin v = 1'b0; d = 8'h77; end
      else             begin v = 1'($urandom_range(0, 1)); d = 8'($urandom); end
      tx_valid = v; din = d;
      @(posedge clk); @(negedge clk);
      total++;
      if ({l0, l1, os_sent, data_os, tx_ready} !== {v ? d : 8'h00, 8'h00, 1'b0, v, 1'b1}) begin
        bad++; $display("FAIL data_byte%0d got=%h exp=%h", n, {l0, l1, os_sent, data_os, tx_ready},
                        {v ? d : 8'h00, 8'h00, 1'b0, v, 1'b1});
      end
    end
    d = 8'($urandom); tx_valid = 1'b1; din = d; d_sel = idle_code();
    @(posedge clk); @(negedge clk);
    tx_valid = 1'b0;
    total++;
    if ({l0, l1, os_sent, data_os, tx_ready} !== {d, 8'h00, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL data_drain got=%h exp=%h", {l0, l1, os_sent, data_os, tx_ready}, {d, 8'h00, 3'b010});
    end
    @(posedge clk); @(negedge clk);
    total++;
    if ({l0, l1, os_sent, data_os, tx_ready} !== 19'h0) begin
      bad++; $display("FAIL data_exit_idle got=%h exp=0", {l0, l1, os_sent, data_os, tx_ready});
    end
  endtask

  task automatic test_abort();
    int c, n;
    c = $urandom_range(2, 3);
    n = $urandom_range(1, 6);
    build_frame(c);
    d_sel = 4'(c);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ({l0, l1} !== {e0[k], e1[k]}) begin
        bad++; $display("FAIL abort_pre_b%0d got=%h exp=%h", k, {l0, l1}, {e0[k], e1[k]});
      end
    end
    lane_tx_on = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ({l0, l1, os_sent, data_os, tx_ready} !== 19'h0) begin
        bad++; $display("FAIL abort_zero%0d got=%h exp=0", k, {l0, l1, os_sent, data_os, tx_ready});
      end
    end
    lane_tx_on = 1'b1;
    for (int k = 0; k < elen; k++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ({l0, l1, os_sent} !== {e0[k], e1[k], k == elen - 1}) begin
        bad++; $display("FAIL abort_restart_b%0d got=%h exp=%h", k, {l0, l1, os_sent}, {e0[k], e1[k], k == elen - 1});
      end
    end
    d_sel = idle_code();
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_os_frames();
    test_midframe_switch();
    test_data();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
